ciphertext_fold_rescale: RTL and testbench
==========================================

Name: ciphertext_fold_rescale

Overview:
Downstream stage of the ciphertext multiplier. It consumes the 2*DIMENSION+1 product coefficients, lowest index first. It folds them negacyclically into ring degree n = DIMENSION+1 (reduction mod x^n+1). Each folded coefficient is then rescaled by t/q with round-half-up, and the n result coefficients are streamed out over a valid/ready handshake.

Parameters:
PLAINTEXT_MODULUS, 64, t; must equal 2^PLAINTEXT_WIDTH
PLAINTEXT_WIDTH, 6, bits of t
DIMENSION, 1, ring degree n = DIMENSION+1; product length 2*DIMENSION+1
CIPHERTEXT_MODULUS, 1024, q; must equal 2^CIPHERTEXT_WIDTH
CIPHERTEXT_WIDTH, 10, coefficient width
IDX_WIDTH, 4, index width; must satisfy 2^IDX_WIDTH > 2*DIMENSION

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
in_valid  in  1  product coefficient valid
in_ready  out  1  block accepts a coefficient
in_data  in  CIPHERTEXT_WIDTH  product coefficient p[i], already mod q
in_last  in  1  marks p[2*DIMENSION]
out_valid  out  1  rescaled coefficient valid
out_ready  in  1  consumer accepts
out_data  out  CIPHERTEXT_WIDTH  rescaled coefficient r[k]
out_index  out  IDX_WIDTH  k of out_data
busy  out  1  high in EMIT, or in LOAD with count != 0
err  out  1  sticky framing error

Behaviour:
- Reset (rst_n low at posedge):
  - state = LOAD; input count = 0; k = 0.
  - out_valid = 0, out_data = 0, out_index = 0, err = 0, busy = 0.
  - Buffer contents are don't-care.
  - Reset overrides any in-flight frame, in either state.
- State LOAD:
  - in_ready = 1, out_valid = 0.
  - On in_valid && in_ready, store p[count] = in_data and increment count.
  - When p[2*DIMENSION] is accepted: next state EMIT, count = 0, and the output register is loaded with r[0], out_index = 0.
  - out_valid rises on the cycle after the last accept (latency 1).
- Framing:
  - in_last accepted with count < 2*DIMENSION: err = 1, count = 0, frame dropped, remain LOAD, no output produced.
  - Final coefficient accepted without in_last: err = 1, frame still processed normally.
  - err is cleared only by reset.
- State EMIT:
  - in_ready = 0, out_valid = 1.
  - out_data and out_index hold stable while out_ready is low.
  - On out_ready with k < DIMENSION: load r[k+1] next cycle, k++.
  - On out_ready with k == DIMENSION: out_valid = 0 next cycle, k = 0, state = LOAD.
  - Back-to-back frames therefore incur one idle input cycle per frame (no accept on the EMIT->LOAD cycle boundary).
- Fold:
  - For k < DIMENSION: c[k] = (p[k] - p[k+DIMENSION+1]) mod q, computed as a CIPHERTEXT_WIDTH-bit wrapping subtraction.
  - c[DIMENSION] = p[DIMENSION].
- Rescale:
  - r[k] = ((c[k] * t + q/2) >> CIPHERTEXT_WIDTH) mod q.
  - Intermediate width is CIPHERTEXT_WIDTH+PLAINTEXT_WIDTH+1 bits; no overflow allowed.
  - c[k] is treated as unsigned in [0, q-1].
  - Each r[k] is computed from the buffer when it is loaded into the output register; no multi-cycle arithmetic.
- Simultaneous events:
  - in_valid during EMIT is ignored (in_ready = 0).
  - out_ready during LOAD has no effect.

Test Plan:
- D=1, frame p = {100, 300, 40} with in_last on 40, out_ready held 1 -> out (idx0 = 4), (idx1 = 19); out_valid high exactly 2 cycles, starting 1 cycle after the third accept.
- Negacyclic wrap: p = {10, 0, 20} -> c0 = 1014 -> r0 = 63; r1 = 0.
- Rounding boundary: p = {8, 7, 0} -> r0 = 1, r1 = 0 (c*64 + 512 = 1024 and 960).
- Backpressure: out_ready low 5 cycles during EMIT -> idx0/value held stable, in_ready = 0 throughout; no coefficient lost or duplicated after release.
- Framing: in_last on the second coefficient -> err = 1, no out_valid. The following valid frame {100, 300, 40} still yields 4, 19, with err remaining 1.
- Reset asserted mid-EMIT after idx0 handshake -> next cycle out_valid = 0, err = 0, in_ready = 1. A fresh frame then produces outputs from idx0.

Source files
------------

// File: rtl/ciphertext_fold_rescale.sv
// Negacyclic fold of a 2*DIMENSION+1 coefficient product into degree DIMENSION+1,
// followed by a t/q round-half-up rescale, streamed out over valid/ready.
module ciphertext_fold_rescale #(
  parameter int PLAINTEXT_MODULUS  = 64,
  parameter int PLAINTEXT_WIDTH    = 6,
  parameter int DIMENSION          = 1,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CIPHERTEXT_WIDTH   = 10,
  parameter int IDX_WIDTH          = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CIPHERTEXT_WIDTH-1:0] in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CIPHERTEXT_WIDTH-1:0] out_data,
  output logic [IDX_WIDTH-1:0]        out_index,
  output logic                        busy,
  output logic                        err
);

  localparam int PLEN = 2 * DIMENSION + 1;
  localparam int IW   = CIPHERTEXT_WIDTH + PLAINTEXT_WIDTH + 1;
  localparam int HALF = CIPHERTEXT_MODULUS / 2;

  typedef enum logic {ST_LOAD, ST_EMIT} state_t;

  state_t                      r_state;
  logic [IDX_WIDTH-1:0]        r_count;
  logic [IDX_WIDTH-1:0]        r_k;
  logic                        r_out_valid;
  logic [CIPHERTEXT_WIDTH-1:0] r_out_data;
  logic [IDX_WIDTH-1:0]        r_out_index;
  logic                        r_err;
  logic [CIPHERTEXT_WIDTH-1:0] r_buf [PLEN];

  logic                        w_acc;
  logic                        w_final;
  logic [IDX_WIDTH-1:0]        w_sel;
  logic [CIPHERTEXT_WIDTH-1:0] w_p [PLEN];
  logic [CIPHERTEXT_WIDTH-1:0] w_c;

  function automatic logic [CIPHERTEXT_WIDTH-1:0] rescale(input logic [CIPHERTEXT_WIDTH-1:0] c);
    logic [IW-1:0] prod;
    prod = IW'(c) * IW'(PLAINTEXT_MODULUS) + IW'(HALF);
    return CIPHERTEXT_WIDTH'(prod >> CIPHERTEXT_WIDTH);
  endfunction

  assign in_ready  = (r_state == ST_LOAD);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign err       = r_err;
  assign busy      = (r_state == ST_EMIT) || (r_count != '0);

  assign w_acc   = in_valid && (r_state == ST_LOAD);
  assign w_final = (r_count == IDX_WIDTH'(2 * DIMENSION));
  assign w_sel   = (r_state == ST_LOAD) ? '0 : r_k + 1'b1;

  // The final coefficient is still on in_data when r[0] is computed, so bypass it in.
  always_comb begin
    for (int i = 0; i < PLEN; i++) begin
      w_p[i] = (w_acc && r_count == IDX_WIDTH'(i)) ? in_data : r_buf[i];
    end
  end

  always_comb begin
    w_c = w_p[DIMENSION];
    for (int j = 0; j < DIMENSION; j++) begin
      if (w_sel == IDX_WIDTH'(j)) w_c = w_p[j] - w_p[j + DIMENSION + 1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PLEN; i++) begin
      if (w_acc && r_count == IDX_WIDTH'(i)) r_buf[i] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_LOAD;
      r_count     <= '0;
      r_k         <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_acc) begin
            if (in_last && !w_final) begin
              // Short frame: drop it and restart collection.
              r_err   <= 1'b1;
              r_count <= '0;
            end else if (w_final) begin
              if (!in_last) r_err <= 1'b1;
              r_count     <= '0;
              r_k         <= '0;
              r_state     <= ST_EMIT;
              r_out_valid <= 1'b1;
              r_out_data  <= rescale(w_c);
              r_out_index <= '0;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (r_k == IDX_WIDTH'(DIMENSION)) begin
              r_out_valid <= 1'b0;
              r_k         <= '0;
              r_state     <= ST_LOAD;
            end else begin
              r_k         <= r_k + 1'b1;
              r_out_data  <= rescale(w_c);
              r_out_index <= r_k + 1'b1;
            end
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_ciphertext_fold_rescale.sv
// Bench for ciphertext_fold_rescale (DIMENSION=1, t=64, q=1024): directed and
// random frames compared against an arithmetic reference of fold and rescale.
module tb_ciphertext_fold_rescale;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_data;
  logic [3:0] out_index;
  logic       busy;
  logic       err;

  int errors = 0;
  int checks = 0;
  bit exp_err = 0;

  ciphertext_fold_rescale dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: fold mod x^2+1 then round(c*t/q) with half-up, all in plain integers.
  function automatic int model_r(input int p0, input int p1, input int p2, input int k);
    int c;
    if (k == 0) c = ((p0 - p2) % 1024 + 1024) % 1024;
    else        c = p1;
    return ((c * 64 + 512) / 1024) % 1024;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send a full 3-coefficient frame, then drain its two outputs with an optional stall on idx0.
  task automatic do_frame(input int p0, input int p1, input int p2, input bit last_ok, input int stall);
    int p [3];
    int exp_r [2];
    p[0] = p0; p[1] = p1; p[2] = p2;
    exp_r[0] = model_r(p0, p1, p2, 0);
    exp_r[1] = model_r(p0, p1, p2, 1);
    if (!last_ok) exp_err = 1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 10'(p[i]);
      in_last  = (i == 2) && last_ok;
      chk("in_ready_load", in_ready, 1);
      tick();
      if (i < 2) chk("busy_loading", busy, 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("latency_out_valid", out_valid, 1);
    chk("err_after_frame", err, exp_err);
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        for (int s = 0; s < stall; s++) begin
          in_valid = 1'b1;
          in_data  = 10'($urandom_range(0, 1023));
          chk("stall_valid", out_valid, 1);
          chk("stall_index", out_index, 0);
          chk("stall_data", out_data, exp_r[0]);
          chk("stall_in_ready", in_ready, 0);
          tick();
        end
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      chk("out_valid", out_valid, 1);
      chk("out_index", out_index, k);
      chk("out_data", out_data, exp_r[k]);
      chk("busy_emit", busy, 1);
      tick();
    end
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    do_frame(100, 300, 40, 1, 0);
    chk("basic_r0_model", model_r(100, 300, 40, 0), 4);
    chk("basic_r1_model", model_r(100, 300, 40, 1), 19);
    do_frame(10, 0, 20, 1, 0);
    chk("wrap_r0_model", model_r(10, 0, 20, 0), 63);
    do_frame(8, 7, 0, 1, 0);
    chk("round_r0_model", model_r(8, 7, 0, 0), 1);
    do_frame(100, 300, 40, 1, 5);

    // Short frame: in_last on the second coefficient.
    in_valid = 1'b1; in_data = 10'd55; in_last = 1'b0;
    tick();
    in_data = 10'd66; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    exp_err = 1;
    chk("short_err", err, 1);
    chk("short_no_valid", out_valid, 0);
    chk("short_busy", busy, 0);
    tick();
    chk("short_no_valid2", out_valid, 0);
    do_frame(100, 300, 40, 1, 0);
    chk("err_sticky", err, 1);

    // Reset during EMIT after the idx0 handshake.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 10'(i * 100 + 7);
      in_last = (i == 2);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    chk("pre_rst_index", out_index, 0);
    tick();
    out_ready = 1'b0;
    chk("pre_rst_idx1", out_index, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_err = 0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_err", err, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    do_frame(10, 0, 20, 1, 2);

    // Missing in_last on the final coefficient still processes the frame.
    do_frame(500, 600, 700, 0, 0);

    exp_err = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      do_frame(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
               int'($urandom_range(0, 1023)), 1, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
